// File: rtl/boxcar_avg_nch.sv
// Multi-lane accumulate-and-dump averager: one decimated mean per 2**n_lat valid samples.
// Optional round-half-up output selected by defining AVG_ROUND_EN (floor when undefined).
module boxcar_avg_nch #(
    parameter int unsigned N        = 16,
    parameter int unsigned NCH      = 4,
    parameter int unsigned MAX_LOG2 = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCH*N-1:0]              x,
    input  logic                          x_valid,
    input  logic [$clog2(MAX_LOG2+1)-1:0] n_avgs_in,
    input  logic                          clear,
    output logic [NCH*N-1:0]              y,
    output logic                          y_valid,
    output logic                          frame_busy
);
    localparam int unsigned LW = $clog2(MAX_LOG2 + 1);
    localparam int unsigned AW = N + MAX_LOG2;
    localparam int unsigned CW = MAX_LOG2;
    localparam logic [CW:0] ONE = (CW + 1)'(1);

    logic [AW-1:0]    acc_q   [NCH];
    logic [AW-1:0]    acc_sum [NCH];
    logic [CW-1:0]    cnt_q;
    logic [LW-1:0]    n_lat_q;
    logic [LW-1:0]    n_clamp;
    logic [LW-1:0]    n_eff;
    logic [CW-1:0]    last_idx;
    logic             last;
    logic [NCH*N-1:0] y_q;
    logic [NCH*N-1:0] y_next;
    logic             y_valid_q;
`ifdef AVG_ROUND_EN
    logic [AW-1:0]    rnd;
`endif

    always_comb begin
        n_clamp = (n_avgs_in > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : n_avgs_in;
        // The first sample of a frame already uses the freshly sampled frame length.
        n_eff    = (cnt_q == '0) ? n_clamp : n_lat_q;
        last_idx = CW'((ONE << n_eff) - ONE);
        last     = x_valid && (cnt_q == last_idx);
`ifdef AVG_ROUND_EN
        rnd = AW'(ONE << n_eff) >> 1;
`endif
        y_next = '0;
        for (int k = 0; k < NCH; k++) begin
            acc_sum[k] = acc_q[k] + AW'(x[k*N +: N]);
`ifdef AVG_ROUND_EN
            y_next[k*N +: N] = N'((acc_sum[k] + rnd) >> n_eff);
`else
            y_next[k*N +: N] = N'(acc_sum[k] >> n_eff);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= '0;
            end
            cnt_q     <= '0;
            n_lat_q   <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            if (clear) begin
                for (int k = 0; k < NCH; k++) begin
                    acc_q[k] <= '0;
                end
                cnt_q <= '0;
            end else if (x_valid) begin
                if (cnt_q == '0) begin
                    n_lat_q <= n_clamp;
                end
                if (last) begin
                    for (int k = 0; k < NCH; k++) begin
                        acc_q[k] <= '0;
                    end
                    cnt_q     <= '0;
                    y_q       <= y_next;
                    y_valid_q <= 1'b1;
                end else begin
                    for (int k = 0; k < NCH; k++) begin
                        acc_q[k] <= acc_sum[k];
                    end
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign y          = y_q;
    assign y_valid    = y_valid_q;
    assign frame_busy = (cnt_q != '0);

endmodule

// File: tb/tb_boxcar_avg_nch.sv
// Self-checking bench for boxcar_avg_nch: frame-level reference model plus literal pins.
module tb_boxcar_avg_nch;
    localparam int N        = 16;
    localparam int NCH      = 4;
    localparam int MAX_LOG2 = 7;
    localparam int LW       = 3;
`ifdef AVG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH*N-1:0] x;
    logic             x_valid;
    logic [LW-1:0]    n_avgs_in;
    logic             clear;
    logic [NCH*N-1:0] y;
    logic             y_valid;
    logic             frame_busy;

    boxcar_avg_nch #(.N(N), .NCH(NCH), .MAX_LOG2(MAX_LOG2)) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .x_valid    (x_valid),
        .n_avgs_in  (n_avgs_in),
        .clear      (clear),
        .y          (y),
        .y_valid    (y_valid),
        .frame_busy (frame_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int cyc    = 0;

    // Reference model state: samples gathered so far in the current frame.
    longint     sums [NCH];
    int         fill;
    int         flen;
    int         exp_y [NCH];
    bit         exp_yv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NCH*N-1:0] lanes(input int a, input int b, input int c, input int d);
        return {N'(d), N'(c), N'(b), N'(a)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            sums[k]  = 0;
            exp_y[k] = 0;
        end
        fill   = 0;
        flen   = 1;
        exp_yv = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [NCH*N-1:0] xin, input int n,
                              input logic clr);
        exp_yv = 1'b0;
        if (clr) begin
            fill = 0;
            for (int k = 0; k < NCH; k++) sums[k] = 0;
        end else if (v) begin
            if (fill == 0) flen = 1 << ((n > MAX_LOG2) ? MAX_LOG2 : n);
            for (int k = 0; k < NCH; k++) sums[k] += longint'(xin[k*N +: N]);
            fill++;
            if (fill == flen) begin
                for (int k = 0; k < NCH; k++) begin
                    exp_y[k] = int'((sums[k] + (ROUND ? flen / 2 : 0)) / flen);
                    sums[k]  = 0;
                end
                exp_yv = 1'b1;
                fill   = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NCH*N-1:0] ev;
        for (int k = 0; k < NCH; k++) ev[k*N +: N] = N'(exp_y[k]);
        chk("y", y, ev);
        chk("y_valid", y_valid, exp_yv);
        chk("frame_busy", frame_busy, fill != 0);
    endtask

    // Drive one cycle, let the edge happen, then compare DUT against the model.
    task automatic step(input logic v, input logic [NCH*N-1:0] xin, input int n,
                        input logic clr);
        x         = xin;
        x_valid   = v;
        n_avgs_in = LW'(n);
        clear     = clr;
        @(posedge clk);
        model_edge(v, xin, n, clr);
        cyc++;
        #1;
        check_outputs();
        if (y_valid) pulses++;
    endtask

    initial begin
        int prev;
        rst = 1'b1; x = '0; x_valid = 1'b0; n_avgs_in = '0; clear = 1'b0;
        model_reset();
        #12;
        check_outputs();
        chk("reset_y", y, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // n=1: lane0 10,20 -> 15; lane1 10,11 -> 10 floor / 11 rounded
        step(1'b1, lanes(10, 10, 0, 1), 1, 1'b0);
        chk("t2_no_early_valid", y_valid, 1'b0);
        step(1'b1, lanes(20, 11, 0, 2), 1, 1'b0);
        chk("t2_valid", y_valid, 1'b1);
        chk("t2_lane0", y[15:0], 16'd15);
        chk("t2_lane1", y[31:16], ROUND ? 16'd11 : 16'd10);
        step(1'b0, lanes(0, 0, 0, 0), 1, 1'b0);

        // Async reset mid-frame (cnt=3, n=2) clears everything immediately.
        for (int i = 0; i < 3; i++) step(1'b1, lanes(1, 2, 3, 4), 2, 1'b0);
        chk("t1_busy_before", frame_busy, 1'b1);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("t1_y_zero", y, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) step(1'b1, lanes(4 * i, 4 * i, 4 * i, 4 * i), 2, 1'b0);
        chk("t1_fresh_valid", y_valid, 1'b1);
        chk("t1_fresh_lane0", y[15:0], 16'd10);

        // n=3 ramp with gaps: single pulse, lane0 mean 3.5
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, lanes(i, i + 1, i + 2, i + 3), 3, 1'b0);
            step(1'b0, lanes(99, 99, 99, 99), 3, 1'b0);
        end
        chk("t3_pulses", pulses, 1);
        chk("t3_lane0", y[15:0], ROUND ? 16'd4 : 16'd3);
        chk("t3_lane3", y[63:48], ROUND ? 16'd7 : 16'd6);

        // n changes 2->0 mid-frame: frame still needs 4 samples, then passthrough
        step(1'b1, lanes(4, 4, 4, 4), 2, 1'b0);
        step(1'b1, lanes(8, 8, 8, 8), 2, 1'b0);
        step(1'b1, lanes(12, 12, 12, 12), 0, 1'b0);
        chk("t4_no_early", y_valid, 1'b0);
        step(1'b1, lanes(16, 16, 16, 16), 0, 1'b0);
        chk("t4_frame_lane0", y[15:0], 16'd10);
        step(1'b1, lanes(7, 7, 7, 7), 0, 1'b0);
        chk("t4_pass_valid", y_valid, 1'b1);
        chk("t4_pass_lane2", y[47:32], 16'd7);
        step(1'b0, lanes(0, 0, 0, 0), 0, 1'b0);

        // clear with x_valid on 3rd sample discards the frame
        pulses = 0;
        step(1'b1, lanes(50, 50, 50, 50), 2, 1'b0);
        step(1'b1, lanes(60, 60, 60, 60), 2, 1'b0);
        step(1'b1, lanes(70, 70, 70, 70), 2, 1'b1);
        chk("t5_y_held", y[15:0], 16'd7);
        chk("t5_idle", frame_busy, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, lanes(100, 100, 100, 100), 2, 1'b0);
        chk("t5_pulses", pulses, 1);
        chk("t5_lane1", y[31:16], 16'd100);

        // Full-scale input, max frame, back-to-back frames
        pulses = 0;
        prev   = -1;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, lanes(65535, 65535, 65535, 65535), 7, 1'b0);
            if (y_valid) begin
                if (prev >= 0) chk("t6_spacing", cyc - prev, 128);
                prev = cyc;
            end
        end
        chk("t6_pulses", pulses, 2);
        chk("t6_all_lanes", y, {4{16'hFFFF}});
        step(1'b0, lanes(0, 0, 0, 0), 7, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
